// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// Returns {remainder, quotient}; EX holds start_i until ready_o.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] dsr_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic              neg_q_q;
  logic              neg_r_q;

  logic [DATA_W:0]   pr;
  logic [DATA_W-1:0] diff;
  logic              ge;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quo_fin;
  logic [DATA_W-1:0] rem_fin;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic              go;
  logic              last;

  // One restoring step, operand magnitudes and final sign fix-up
  always_comb begin
    pr      = {rem_q, dvd_q[DATA_W-1]};
    ge      = pr >= {1'b0, dsr_q};
    diff    = pr[DATA_W-1:0] - dsr_q;
    rem_nx  = ge ? diff : pr[DATA_W-1:0];
    quo_fin = neg_q_q ? ('0 - quo_q) : quo_q;
    rem_fin = neg_r_q ? ('0 - rem_q) : rem_q;
    a_abs   = (signed_div_i && opdata1_i[DATA_W-1])
            ? ('0 - opdata1_i) : opdata1_i;
    b_abs   = (signed_div_i && opdata2_i[DATA_W-1])
            ? ('0 - opdata2_i) : opdata2_i;
    go      = start_i && !annul_i;
    last    = cnt_q == CW'(DATA_W);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FREE: begin
        if (go)
          state_d = (opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: state_d = END;
      ON: begin
        if (annul_i)   state_d = FREE;
        else if (last) state_d = END;
      end
      END: begin
        if (!start_i || annul_i)
          state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (go) begin
            cnt_q   <= '0;
            dvd_q   <= a_abs;
            dsr_q   <= b_abs;
            quo_q   <= '0;
            rem_q   <= '0;
            neg_q_q <= signed_div_i
                    && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r_q <= signed_div_i && opdata1_i[DATA_W-1];
          end
        end
        BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (!annul_i) begin
            if (!last) begin
              rem_q <= rem_nx;
              quo_q <= {quo_q[DATA_W-2:0], ge};
              dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
              cnt_q <= cnt_q + 1'b1;
            end else begin
              result_o <= {rem_fin, quo_fin};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start_i || annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq.
// Hand-computed vectors, latency and abort checks.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int errors = 0;
  int checks = 0;

  div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a divide, hold start for 'hold' extra cycles after ready,
  // then release start and check the outputs drop one edge later.
  task automatic run(input string tag,
                     input logic sd,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [63:0] exp,
                     input int lat,
                     input int hold);
    int n;
    bit got;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n   = 0;
    got = 0;
    while (n < 60 && !got) begin
      step();
      n++;
      if (ready_o) got = 1;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold"}, {result_o[62:0], ready_o},
          {exp[62:0], 1'b1});
    end
    start_i = 1'b0;
    step();
    chk({tag, "_drop"}, {result_o[62:0], ready_o}, 64'd0);
  endtask

  initial begin
    int n;
    bit seen;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    step();
    step();
    chk("reset", {result_o[62:0], ready_o}, 64'd0);
    rst = 1'b0;
    step();

    run("divu_100_7", 1'b0, 32'd100, 32'd7,
        64'h00000002_0000000E, 34, 0);
    run("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2,
        64'hFFFFFFFF_FFFFFFFD, 34, 0);
    run("div_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE,
        64'h00000001_FFFFFFFD, 34, 0);
    run("divu_fff9_2", 1'b0, 32'hFFFFFFF9, 32'h2,
        64'h00000001_7FFFFFFC, 34, 0);
    run("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
        64'hFFFFFFFE_0000000E, 34, 0);
    run("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
        64'h00000000_80000000, 34, 0);
    run("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'h1,
        64'h00000000_FFFFFFFF, 34, 0);
    run("divu_by0", 1'b0, 32'd55, 32'd0, 64'd0, 2, 0);
    run("div_by0", 1'b1, 32'hFFFFFFF0, 32'd0, 64'd0, 2, 0);

    // annul at cnt=10 (after edge 11)
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    for (int i = 0; i < 11; i++) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ready_o) seen = 1;
    end
    chk("annul_noready", 64'(seen), 64'd0);
    run("divu_9_3", 1'b0, 32'd9, 32'd3,
        64'h00000000_00000003, 34, 0);

    // reset at cnt=20 (after edge 21)
    opdata1_i = 32'd500;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    for (int i = 0; i < 21; i++) step();
    rst = 1'b1;
    step();
    chk("rst_mid", {result_o[62:0], ready_o}, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    step();

    // stall 5 cycles in END
    run("divu_stall", 1'b0, 32'd50, 32'd6,
        64'h00000002_00000008, 34, 5);

    // operands changed and start dropped after acceptance
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd10;
    start_i      = 1'b1;
    step();
    opdata1_i    = 32'd5;
    opdata2_i    = 32'd3;
    signed_div_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    start_i = 1'b0;
    n    = 4;
    seen = 0;
    while (n < 60 && !seen) begin
      step();
      n++;
      if (ready_o) seen = 1;
    end
    chk("latch_lat", 64'(n), 64'd34);
    chk("latch_res", result_o, 64'h00000000_00000064);
    step();
    chk("latch_drop", {result_o[62:0], ready_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
